// File: rtl/btb_update_scheduler_if.sv
// Bundle of the lookup, update-requester and BTB-side signals of the
// BTB update scheduler.
// Valid/ready rule for the lookup and both update channels: a transfer
// happens on a rising clk edge with clk_en high where valid and ready are
// both high; ready may depend on valid, valid must not depend on ready.
interface btb_update_scheduler_if #(
    parameter int DATABITWIDTH           = 16,
    parameter int PREDICTORINDEXBITWIDTH = 6
);
    logic                              LookupValid;
    logic [PREDICTORINDEXBITWIDTH-1:0] LookupAddress;
    logic                              LookupReady;

    logic                              Upd0Valid;
    logic                              Upd0Ready;
    logic [PREDICTORINDEXBITWIDTH-1:0] Upd0Address;
    logic [DATABITWIDTH-1:0]           Upd0Destination;
    logic                              Upd0Taken;

    logic                              Upd1Valid;
    logic                              Upd1Ready;
    logic [PREDICTORINDEXBITWIDTH-1:0] Upd1Address;
    logic [DATABITWIDTH-1:0]           Upd1Destination;
    logic                              Upd1Taken;

    logic [PREDICTORINDEXBITWIDTH-1:0] BtbAddress;
    logic                              BtbClear;
    logic                              BtbUpdateEnable;
    logic                              BtbPredictingRegisterBranch;
    logic [DATABITWIDTH-1:0]           BtbActualDestination;
    logic                              BtbBranchTaken;

    // Requester / fetch / BTB side (the environment around the scheduler).
    modport master (
        output LookupValid, LookupAddress,
        output Upd0Valid, Upd0Address, Upd0Destination, Upd0Taken,
        output Upd1Valid, Upd1Address, Upd1Destination, Upd1Taken,
        input  LookupReady, Upd0Ready, Upd1Ready,
        input  BtbAddress, BtbClear, BtbUpdateEnable, BtbPredictingRegisterBranch,
        input  BtbActualDestination, BtbBranchTaken
    );

    // Scheduler side.
    modport slave (
        input  LookupValid, LookupAddress,
        input  Upd0Valid, Upd0Address, Upd0Destination, Upd0Taken,
        input  Upd1Valid, Upd1Address, Upd1Destination, Upd1Taken,
        output LookupReady, Upd0Ready, Upd1Ready,
        output BtbAddress, BtbClear, BtbUpdateEnable, BtbPredictingRegisterBranch,
        output BtbActualDestination, BtbBranchTaken
    );
endinterface

// File: rtl/btb_update_scheduler.sv
// Sequences the single BTB address port between the fetch lookup, a
// post-reset/flush clear sweep and a small FIFO of resolved-branch updates
// fed round-robin by two resolvers. Lookup wins the port unless the FIFO is
// full or the head update has been starved for STARVELIMIT lookup cycles.
// The two-state FSM is visible outside as ClearBusy (high exactly in CLEAR).
module btb_update_scheduler #(
    parameter int DATABITWIDTH           = 16,
    parameter int PREDICTORDEPTH         = 64,
    parameter int PREDICTORINDEXBITWIDTH = $clog2(PREDICTORDEPTH),
    parameter int UPDATEFIFODEPTH        = 4,
    parameter int STARVELIMIT            = 8
) (
    input  logic                      clk,
    input  logic                      async_rst_n,
    input  logic                      clk_en,
    input  logic                      FlushRequest,
    output logic                      ClearBusy,
    btb_update_scheduler_if.slave     bus
);
    localparam int IW = PREDICTORINDEXBITWIDTH;
    localparam int DW = DATABITWIDTH;
    localparam int PW = $clog2(UPDATEFIFODEPTH);
    localparam int SW = $clog2(STARVELIMIT + 1);
    localparam logic [IW-1:0] LAST_INDEX = IW'(PREDICTORDEPTH - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVELIMIT);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [IW-1:0] r_sweep_count;
    logic [IW-1:0] r_fifo_addr  [UPDATEFIFODEPTH];
    logic [DW-1:0] r_fifo_dest  [UPDATEFIFODEPTH];
    logic          r_fifo_taken [UPDATEFIFODEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          r_rr_ptr;
    logic [SW-1:0] r_starve_count;

    logic w_run, w_flush, w_empty, w_full, w_force;
    logic w_grant0, w_grant1, w_enq_ok, w_push;
    logic w_lookup_win, w_drain, w_pop;
    logic [PW-1:0] w_head;
    logic [PW-1:0] w_tail;

    assign w_run   = (r_state == ST_RUN);
    assign w_flush = FlushRequest & clk_en;
    assign w_head  = r_rd_ptr[PW-1:0];
    assign w_tail  = r_wr_ptr[PW-1:0];
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (w_tail == w_head);
    assign w_force = w_full | (r_starve_count >= STARVE_MAX);

    // Round-robin pick only matters when both resolvers request together.
    assign w_grant0 = bus.Upd0Valid & (~bus.Upd1Valid | ~r_rr_ptr);
    assign w_grant1 = bus.Upd1Valid & (~bus.Upd0Valid |  r_rr_ptr);
    // Fullness is judged before any same-cycle pop: no enqueue when full.
    assign w_enq_ok      = w_run & ~w_full & ~FlushRequest;
    assign bus.Upd0Ready = w_enq_ok & w_grant0;
    assign bus.Upd1Ready = w_enq_ok & w_grant1;
    assign w_push        = (bus.Upd0Ready | bus.Upd1Ready) & clk_en;

    assign w_lookup_win    = w_run & ~w_empty & bus.LookupValid & ~w_force;
    assign w_drain         = w_run & ~w_empty & ~(bus.LookupValid & ~w_force) & ~FlushRequest;
    assign w_pop           = w_drain & clk_en;
    assign bus.LookupReady = w_run & bus.LookupValid & (w_empty | ~w_force);
    assign bus.BtbPredictingRegisterBranch = bus.BtbUpdateEnable;

    // Port mux: sweep address in CLEAR, FIFO head on a drain, lookup otherwise.
    always_comb begin
        ClearBusy                = 1'b0;
        bus.BtbClear             = 1'b0;
        bus.BtbAddress           = bus.LookupAddress;
        bus.BtbUpdateEnable      = 1'b0;
        bus.BtbActualDestination = '0;
        bus.BtbBranchTaken       = 1'b0;
        if (!w_run) begin
            ClearBusy      = 1'b1;
            bus.BtbClear   = 1'b1;
            bus.BtbAddress = r_sweep_count;
        end else if (w_drain) begin
            bus.BtbUpdateEnable      = 1'b1;
            bus.BtbAddress           = r_fifo_addr[w_head];
            bus.BtbActualDestination = r_fifo_dest[w_head];
            bus.BtbBranchTaken       = r_fifo_taken[w_head];
        end
    end

    // Next state: flush always restarts the sweep; sweep ends on the last index.
    always_comb begin
        w_next_state = r_state;
        if (clk_en) begin
            if (FlushRequest) begin
                w_next_state = ST_CLEAR;
            end else if ((r_state == ST_CLEAR) && (r_sweep_count == LAST_INDEX)) begin
                w_next_state = ST_RUN;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) r_state <= ST_CLEAR;
        else              r_state <= w_next_state;
    end

    // Sweep counter; wraps back to 0 as the sweep completes (power-of-2 depth).
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_sweep_count <= '0;
        end else if (clk_en) begin
            if (FlushRequest)                r_sweep_count <= '0;
            else if (r_state == ST_CLEAR)    r_sweep_count <= r_sweep_count + IW'(1);
        end
    end

    // FIFO pointers, round-robin pointer and starvation counter.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_rr_ptr       <= 1'b0;
            r_starve_count <= '0;
        end else if (w_flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_starve_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
                r_rr_ptr <= bus.Upd0Ready;
            end
            if (w_pop) begin
                r_rd_ptr       <= r_rd_ptr + (PW+1)'(1);
                r_starve_count <= '0;
            end else if (clk_en && w_lookup_win && (r_starve_count < STARVE_MAX)) begin
                r_starve_count <= r_starve_count + SW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[w_tail]  <= bus.Upd0Ready ? bus.Upd0Address     : bus.Upd1Address;
            r_fifo_dest[w_tail]  <= bus.Upd0Ready ? bus.Upd0Destination : bus.Upd1Destination;
            r_fifo_taken[w_tail] <= bus.Upd0Ready ? bus.Upd0Taken       : bus.Upd1Taken;
        end
    end
endmodule
